muldiv_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer owning the architectural HI/LO registers for the MIPS datapath. It accepts one operation at a time from the EX stage and runs multiply, multiply-accumulate, and iterative divide. It holds the pipeline through `Busy` until results are committed to HI/LO. `mfhi`/`mflo` read `Hi`/`Lo` directly.

---
 rtl/muldiv_sequencer_if.sv | 23 ++
 rtl/muldiv_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX stage and the multiply/divide sequencer.
// The EX stage drives the master side; the sequencer implements the slave side.
interface muldiv_sequencer_if;
    logic        Start;
    logic [3:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cancel;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    modport master (
        output Start, Op, A, B, Cancel,
        input  Busy, Done, Hi, Lo
    );

    modport slave (
        input  Start, Op, A, B, Cancel,
        output Busy, Done, Hi, Lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO registers.
// Multiplies take one cycle in MUL; divides run a 32-step restoring divider then a
// sign-fix cycle. The divider is only built when MULDIV_DIV_EN is defined; otherwise
// DIV/DIVU are accepted as NOPs.
module muldiv_sequencer (
    input logic              Clk,
    input logic              Rst,
    muldiv_sequencer_if.slave bus
);

    localparam logic [3:0] OpMult  = 4'b0001;
    localparam logic [3:0] OpMultu = 4'b0010;
    localparam logic [3:0] OpMadd  = 4'b0011;
    localparam logic [3:0] OpMsub  = 4'b0100;
`ifdef MULDIV_DIV_EN
    localparam logic [3:0] OpDiv   = 4'b0101;
    localparam logic [3:0] OpDivu  = 4'b0110;
`endif
    localparam logic [3:0] OpMthi  = 4'b0111;
    localparam logic [3:0] OpMtlo  = 4'b1000;

`ifdef MULDIV_DIV_EN
    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;
`else
    typedef enum logic [0:0] {StIdle, StMul} state_e;
`endif

    state_e      r_state, w_state_next;
    logic [31:0] r_hi, w_hi_next;
    logic [31:0] r_lo, w_lo_next;
    logic [31:0] r_a, w_a_next;
    logic [31:0] r_b, w_b_next;
    logic [3:0]  r_op, w_op_next;
    logic        r_done, w_done_next;
    logic        w_accept;

    // Multiplier datapath: sign- or zero-extend to 64 bits, keep the low 64 product bits.
    logic        w_mul_signed;
    logic [63:0] w_ext_a, w_ext_b, w_prod, w_acc;

    assign w_accept     = bus.Start && !bus.Cancel && (r_state == StIdle);
    assign w_mul_signed = (r_op != OpMultu);
    assign w_ext_a      = w_mul_signed ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
    assign w_ext_b      = w_mul_signed ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
    assign w_prod       = w_ext_a * w_ext_b;
    assign w_acc        = {r_hi, r_lo};

`ifdef MULDIV_DIV_EN
    logic [31:0] r_quot, w_quot_next;
    logic [31:0] r_rem, w_rem_next;
    logic [4:0]  r_cnt, w_cnt_next;

    // Divider datapath: r_quot starts as |dividend| and fills with quotient bits from the
    // right as the dividend bits shift out of its top into the partial remainder.
    logic [31:0] w_dvd_mag, w_dvs_mag, w_sub;
    logic [32:0] w_shift;
    logic        w_ge, w_q_neg, w_r_neg;
    logic [31:0] w_q_fix, w_r_fix;

    assign w_dvd_mag = (bus.Op == OpDiv && bus.A[31]) ? 32'd0 - bus.A : bus.A;
    assign w_dvs_mag = (r_op == OpDiv && r_b[31]) ? 32'd0 - r_b : r_b;
    assign w_shift   = {r_rem, r_quot[31]};
    assign w_ge      = (w_shift >= {1'b0, w_dvs_mag});
    // When w_ge holds the difference fits in 32 bits, so the top shift bit can be dropped.
    assign w_sub     = w_shift[31:0] - w_dvs_mag;
    assign w_q_neg   = (r_op == OpDiv) && (r_a[31] ^ r_b[31]);
    assign w_r_neg   = (r_op == OpDiv) && r_a[31];
    assign w_q_fix   = w_q_neg ? 32'd0 - r_quot : r_quot;
    assign w_r_fix   = w_r_neg ? 32'd0 - r_rem : r_rem;
`endif

    // Next-state and commit logic; Cancel in any busy state drops back to idle uncommitted.
    always_comb begin
        w_state_next = r_state;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_op_next    = r_op;
        w_done_next  = 1'b0;
`ifdef MULDIV_DIV_EN
        w_quot_next  = r_quot;
        w_rem_next   = r_rem;
        w_cnt_next   = r_cnt;
`endif
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_a_next  = bus.A;
                    w_b_next  = bus.B;
                    w_op_next = bus.Op;
                    case (bus.Op)
                        OpMthi: begin
                            w_hi_next   = bus.A;
                            w_done_next = 1'b1;
                        end
                        OpMtlo: begin
                            w_lo_next   = bus.A;
                            w_done_next = 1'b1;
                        end
                        OpMult, OpMultu, OpMadd, OpMsub: w_state_next = StMul;
`ifdef MULDIV_DIV_EN
                        OpDiv, OpDivu: begin
                            w_state_next = StDiv;
                            w_quot_next  = w_dvd_mag;
                            w_rem_next   = 32'd0;
                            w_cnt_next   = 5'd0;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            StMul: begin
                w_state_next = StIdle;
                if (!bus.Cancel) begin
                    w_done_next = 1'b1;
                    case (r_op)
                        OpMadd:  {w_hi_next, w_lo_next} = w_acc + w_prod;
                        OpMsub:  {w_hi_next, w_lo_next} = w_acc - w_prod;
                        default: {w_hi_next, w_lo_next} = w_prod;
                    endcase
                end
            end
`ifdef MULDIV_DIV_EN
            StDiv: begin
                if (bus.Cancel) begin
                    w_state_next = StIdle;
                end else begin
                    w_rem_next  = w_ge ? w_sub : w_shift[31:0];
                    w_quot_next = {r_quot[30:0], w_ge};
                    w_cnt_next  = r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        w_state_next = StFix;
                    end
                end
            end
            StFix: begin
                w_state_next = StIdle;
                if (!bus.Cancel) begin
                    w_done_next = 1'b1;
                    // Divide by zero reports all-ones quotient and the raw dividend.
                    if (r_b == 32'd0) begin
                        w_lo_next = 32'hFFFF_FFFF;
                        w_hi_next = r_a;
                    end else begin
                        w_lo_next = w_q_fix;
                        w_hi_next = w_r_fix;
                    end
                end
            end
`endif
            default: w_state_next = StIdle;
        endcase
    end

    // State and architectural register update; reset abandons any operation in flight.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= StIdle;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 4'd0;
            r_done  <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_quot  <= 32'd0;
            r_rem   <= 32'd0;
            r_cnt   <= 5'd0;
`endif
        end else begin
            r_state <= w_state_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_op    <= w_op_next;
            r_done  <= w_done_next;
`ifdef MULDIV_DIV_EN
            r_quot  <= w_quot_next;
            r_rem   <= w_rem_next;
            r_cnt   <= w_cnt_next;
`endif
        end
    end

    assign bus.Busy = (r_state != StIdle);
    assign bus.Done = r_done;
    assign bus.Hi   = r_hi;
    assign bus.Lo   = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: each accepted operation pushes its expected
// HI/LO and Done cycle; a negedge monitor pops and compares on every Done pulse.
module tb_muldiv_sequencer;

    logic Clk = 1'b0;
    logic Rst = 1'b0;

    muldiv_sequencer_if bus ();

    muldiv_sequencer dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc = cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Rst === 1'b1 && bus.Done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got Done=1 at cycle %0d expected none", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check32({e.name, "_hi"}, bus.Hi, e.hi);
                    check32({e.name, "_lo"}, bus.Lo, e.lo);
                    check_int({e.name, "_done_cycle"}, cyc, e.cyc);
                end
            end
        end
    end

    // Reference model: architectural result of one operation from plain arithmetic.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output bit has_done, output int lat,
                         output logic [31:0] nh, output logic [31:0] nl);
        logic [63:0] acc;
        logic [63:0] p;
        int          sa;
        int          sb;
        acc      = {m_hi, m_lo};
        nh       = m_hi;
        nl       = m_lo;
        has_done = 1'b0;
        lat      = 0;
        sa       = a;
        sb       = b;
        case (op)
            4'd1, 4'd3, 4'd4: begin
                p = longint'(sa) * longint'(sb);
                if (op == 4'd1) {nh, nl} = p;
                else if (op == 4'd3) {nh, nl} = acc + p;
                else {nh, nl} = acc - p;
                has_done = 1'b1;
                lat = 1;
            end
            4'd2: begin
                p = {32'd0, a} * {32'd0, b};
                {nh, nl} = p;
                has_done = 1'b1;
                lat = 1;
            end
`ifdef MULDIV_DIV_EN
            4'd5, 4'd6: begin
                if (b == 32'd0) begin
                    nl = 32'hFFFF_FFFF;
                    nh = a;
                end else if (op == 4'd5 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    nl = 32'h8000_0000;
                    nh = 32'd0;
                end else if (op == 4'd5) begin
                    nl = sa / sb;
                    nh = sa % sb;
                end else begin
                    nl = a / b;
                    nh = a % b;
                end
                has_done = 1'b1;
                lat = 33;
            end
`endif
            4'd7: begin nh = a; has_done = 1'b1; end
            4'd8: begin nl = a; has_done = 1'b1; end
            default: ;
        endcase
    endtask

    // Drive one request and return the accept-edge cycle number.
    task automatic start_raw(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int c0);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge Clk);
        #1;
        c0        = cyc;
        bus.Start = 1'b0;
    endtask

    // Full transaction: wait idle, issue, update model, measure Busy and HI/LO stability.
    task automatic do_op(input string name, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        bit          has_done;
        int          lat;
        int          c0;
        int          bcnt;
        int          guard;
        bit          stable;
        logic [31:0] nh, nl, ph, pl;
        exp_t        e;
        guard = 0;
        while (bus.Busy !== 1'b0) begin
            @(negedge Clk);
            guard++;
            if (guard > 100) begin
                check_int({name, "_idle_timeout"}, guard, 0);
                return;
            end
        end
        model(op, a, b, has_done, lat, nh, nl);
        start_raw(op, a, b, c0);
        if (has_done) begin
            e.hi = nh; e.lo = nl; e.cyc = c0 + lat; e.name = name;
            sb_q.push_back(e);
        end
        ph = m_hi; pl = m_lo;
        m_hi = nh; m_lo = nl;
        bcnt = 0;
        stable = 1'b1;
        forever begin
            @(negedge Clk);
            if (bus.Busy !== 1'b1) break;
            bcnt++;
            if (bus.Hi !== ph || bus.Lo !== pl) stable = 1'b0;
            if (bcnt > 60) break;
        end
        check_int({name, "_busy_cycles"}, bcnt, lat);
        check_int({name, "_hilo_stable"}, int'(stable), 1);
    endtask

    initial begin
        int          c0;
        bit          hd;
        int          lat;
        logic [31:0] nh, nl;
        exp_t        e;
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        bus.Start  = 1'b0;
        bus.Op     = 4'd0;
        bus.A      = 32'd0;
        bus.B      = 32'd0;
        bus.Cancel = 1'b0;

        #1;
        check32("reset_busy", {31'd0, bus.Busy}, 32'd0);
        check32("reset_done", {31'd0, bus.Done}, 32'd0);
        check32("reset_hi", bus.Hi, 32'd0);
        check32("reset_lo", bus.Lo, 32'd0);
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);

        do_op("mthi", 4'd7, 32'h1234_5678, 32'd0);
        do_op("mtlo", 4'd8, 32'h9ABC_DEF0, 32'd0);
        check32("mt_hi_const", bus.Hi, 32'h1234_5678);
        check32("mt_lo_const", bus.Lo, 32'h9ABC_DEF0);

        do_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3);
        check32("mult_hi_const", bus.Hi, 32'hFFFF_FFFF);
        check32("mult_lo_const", bus.Lo, 32'hFFFF_FFFA);
        do_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3);
        check32("multu_hi_const", bus.Hi, 32'h0000_0002);

        do_op("mthi0", 4'd7, 32'd0, 32'd0);
        do_op("mtlo10", 4'd8, 32'd10, 32'd0);
        do_op("madd", 4'd3, 32'd4, 32'd5);
        check32("madd_lo_const", bus.Lo, 32'd30);
        do_op("msub", 4'd4, 32'd7, 32'd5);
        check32("msub_hi_const", bus.Hi, 32'hFFFF_FFFF);
        check32("msub_lo_const", bus.Lo, 32'hFFFF_FFFB);

        do_op("div_neg", 4'd5, 32'hFFFF_FFF9, 32'd2);
`ifdef MULDIV_DIV_EN
        check32("div_lo_const", bus.Lo, 32'hFFFF_FFFD);
        check32("div_hi_const", bus.Hi, 32'hFFFF_FFFF);
`endif
        do_op("divu_by0", 4'd6, 32'd100, 32'd0);
        do_op("div_ovf", 4'd5, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("nop", 4'd12, 32'h1111_1111, 32'h2222_2222);

        // Cancel mid-divide: no commit, no Done.
        start_raw(4'd5, 32'd50, 32'd7, c0);
        repeat (9) @(negedge Clk);
        bus.Cancel = 1'b1;
        @(posedge Clk);
        #1;
        bus.Cancel = 1'b0;
        check32("cancel_busy", {31'd0, bus.Busy}, 32'd0);
        repeat (40) @(negedge Clk);
        check32("cancel_hi", bus.Hi, m_hi);
        check32("cancel_lo", bus.Lo, m_lo);

        // Cancel in idle blocks the accept.
        @(negedge Clk);
        bus.Cancel = 1'b1;
        start_raw(4'd7, 32'hDEAD_BEEF, 32'd0, c0);
        bus.Cancel = 1'b0;
        @(negedge Clk);
        check32("cancel_idle_hi", bus.Hi, m_hi);

`ifdef MULDIV_DIV_EN
        // Start held while busy with another op must be ignored.
        model(4'd6, 32'd1000, 32'd3, hd, lat, nh, nl);
        start_raw(4'd6, 32'd1000, 32'd3, c0);
        e.hi = nh; e.lo = nl; e.cyc = c0 + lat; e.name = "divu_held";
        sb_q.push_back(e);
        m_hi = nh; m_lo = nl;
        bus.Start = 1'b1;
        bus.Op    = 4'd7;
        bus.A     = 32'h0000_0055;
        repeat (5) @(negedge Clk);
        bus.Start = 1'b0;
        repeat (40) @(negedge Clk);
        check32("start_busy_ignored_hi", bus.Hi, 32'd1);
`endif

        // Reset mid-divide clears HI/LO immediately.
        do_op("mthi_pre", 4'd7, 32'hA5A5_A5A5, 32'd0);
        start_raw(4'd5, 32'd50, 32'd7, c0);
        repeat (5) @(negedge Clk);
        Rst = 1'b0;
        #1;
        check32("rst_mid_busy", {31'd0, bus.Busy}, 32'd0);
        check32("rst_mid_hi", bus.Hi, 32'd0);
        check32("rst_mid_lo", bus.Lo, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);

        // Randomized operations against the model.
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = 32'($urandom_range(0, 200)) - 32'd100; rb = 32'($urandom_range(1, 9)); end
                default: ;
            endcase
            do_op($sformatf("rand%0d", i), rop, ra, rb);
        end

        repeat (3) @(negedge Clk);
        check_int("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
